// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for the ID stage: tracks in-flight writes to the 8
// architectural registers and decides each cycle whether the ID instruction issues or stalls.
module reg_scoreboard #(
  parameter bit WB_BYPASS   = 1'b1,
  parameter bit R0_ZERO     = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issueValid,
  input  logic                   flush,
  input  logic [2:0]             rs,
  input  logic [2:0]             rt,
  input  logic [2:0]             rd,
  input  logic                   useRs,
  input  logic                   useRt,
  input  logic                   writesRd,
  input  logic                   wbValid,
  input  logic [2:0]             wbReg,
  output logic                   issueAccept,
  output logic                   stall,
  output logic [7:0]             pendingMask,
  output logic [3:0]             pendingCount,
  output logic [STALL_CNT_W-1:0] stallCount,
  output logic                   wbError
);

  logic [7:0] pending;
  logic [7:0] pendingNext;
  logic       hazard;
  logic       live;
  logic       wbMiss;

  function automatic logic isZeroReg(input logic [2:0] r);
    return R0_ZERO && (r == 3'd0);
  endfunction

  // A source read is safe when the bank is writing that same register through this cycle.
  function automatic logic srcHaz(input logic [7:0] pend, input logic [2:0] r,
                                  input logic wbV, input logic [2:0] wbR);
    return pend[r] & ~(WB_BYPASS & wbV & (wbR == r)) & ~isZeroReg(r);
  endfunction

  function automatic logic [3:0] popCount(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] satInc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  always_comb begin
    hazard = (useRs & srcHaz(pending, rs, wbValid, wbReg))
           | (useRt & srcHaz(pending, rt, wbValid, wbReg))
           | (writesRd & pending[rd] & ~isZeroReg(rd));
    live        = issueValid & ~flush;
    issueAccept = live & ~hazard;
    stall       = live & hazard;
    wbMiss      = wbValid & ~pending[wbReg];
  end

  // Clear on writeback first so a same-cycle accepted issue of that register wins.
  always_comb begin
    pendingNext = pending;
    if (wbValid) pendingNext[wbReg] = 1'b0;
    if (issueAccept & writesRd & ~isZeroReg(rd)) pendingNext[rd] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending      <= 8'd0;
      pendingCount <= 4'd0;
      stallCount   <= '0;
      wbError      <= 1'b0;
    end else begin
      pending      <= pendingNext;
      pendingCount <= popCount(pendingNext);
      if (stall) stallCount <= satInc(stallCount);
      if (wbMiss) wbError <= 1'b1;
    end
  end

  assign pendingMask = pending;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: two configurations driven in parallel, each
// checked against its own behavioural model through an expectation queue.
module tb_reg_scoreboard;

  logic        clock;
  logic        reset;
  logic        issueValid, flush, useRs, useRt, writesRd, wbValid;
  logic [2:0]  rs, rt, rd, wbReg;

  logic        iaA, stA, weA;
  logic [7:0]  pmA;
  logic [3:0]  pcA;
  logic [3:0]  scA;
  logic        iaB, stB, weB;
  logic [7:0]  pmB;
  logic [3:0]  pcB;
  logic [15:0] scB;

  reg_scoreboard #(.WB_BYPASS(1'b1), .R0_ZERO(1'b1), .STALL_CNT_W(4)) dutA (
    .clock(clock), .reset(reset), .issueValid(issueValid), .flush(flush),
    .rs(rs), .rt(rt), .rd(rd), .useRs(useRs), .useRt(useRt), .writesRd(writesRd),
    .wbValid(wbValid), .wbReg(wbReg), .issueAccept(iaA), .stall(stA),
    .pendingMask(pmA), .pendingCount(pcA), .stallCount(scA), .wbError(weA));

  reg_scoreboard #(.WB_BYPASS(1'b0), .R0_ZERO(1'b0), .STALL_CNT_W(16)) dutB (
    .clock(clock), .reset(reset), .issueValid(issueValid), .flush(flush),
    .rs(rs), .rt(rt), .rd(rd), .useRs(useRs), .useRt(useRt), .writesRd(writesRd),
    .wbValid(wbValid), .wbReg(wbReg), .issueAccept(iaB), .stall(stB),
    .pendingMask(pmB), .pendingCount(pcB), .stallCount(scB), .wbError(weB));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ia;
    logic        st;
    logic [7:0]  pm;
    logic [3:0]  pc;
    logic [15:0] sc;
    logic        we;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];

  int vectors = 0;
  int miscompares = 0;
  bit driverDone = 0;

  // Model state per configuration (index 0 = bypass/r0-zero/4-bit, 1 = no bypass/plain r0/16-bit)
  bit mPend[2][8];
  int mStall[2];
  bit mErr[2];
  bit cfgByp[2]  = '{1'b1, 1'b0};
  bit cfgR0[2]   = '{1'b1, 1'b0};
  int cfgMax[2]  = '{15, 65535};

  function automatic bit blocks(int k, int r, bit bypassable);
    if (cfgR0[k] && r == 0) return 0;
    if (!mPend[k][r]) return 0;
    if (bypassable && cfgByp[k] && wbValid && int'(wbReg) == r) return 0;
    return 1;
  endfunction

  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      bit haz, live, acc, st;
      int n;
      if (!reset) begin
        for (int r = 0; r < 8; r++) mPend[k][r] = 0;
        mStall[k] = 0;
        mErr[k] = 0;
      end
      haz = 0;
      if (useRs && blocks(k, int'(rs), 1)) haz = 1;
      if (useRt && blocks(k, int'(rt), 1)) haz = 1;
      if (writesRd && blocks(k, int'(rd), 0)) haz = 1;
      live = issueValid && !flush;
      acc = live && !haz;
      st = live && haz;
      n = 0;
      e.pm = 8'd0;
      for (int r = 0; r < 8; r++) begin
        e.pm[r] = mPend[k][r];
        n += int'(mPend[k][r]);
      end
      e.ia = acc;
      e.st = st;
      e.pc = 4'(n);
      e.sc = 16'(mStall[k]);
      e.we = mErr[k];
      if (k == 0) qA.push_back(e);
      else qB.push_back(e);
      if (reset) begin
        if (wbValid && !mPend[k][wbReg]) mErr[k] = 1;
        if (wbValid) mPend[k][wbReg] = 0;
        if (acc && writesRd && !(cfgR0[k] && rd == 3'd0)) mPend[k][rd] = 1;
        if (st && mStall[k] < cfgMax[k]) mStall[k]++;
      end
    end
  endtask

  task automatic cyc(input logic rn, input logic iv, input logic fl,
                     input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                     input logic ua, input logic ub, input logic wd,
                     input logic wv, input logic [2:0] wr);
    @(posedge clock);
    #1;
    reset = rn; issueValid = iv; flush = fl;
    rs = a; rt = b; rd = d; useRs = ua; useRt = ub; writesRd = wd;
    wbValid = wv; wbReg = wr;
    modelStep();
  endtask

  task automatic check(input string nm, input int k, input logic [15:0] act,
                       input logic [15:0] exv);
    if (act !== exv) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exv, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (qA.size() > 0) begin
      e = qA.pop_front();
      vectors++;
      check("issueAccept", 0, {15'd0, iaA}, {15'd0, e.ia});
      check("stall", 0, {15'd0, stA}, {15'd0, e.st});
      check("pendingMask", 0, {8'd0, pmA}, {8'd0, e.pm});
      check("pendingCount", 0, {12'd0, pcA}, {12'd0, e.pc});
      check("stallCount", 0, {12'd0, scA}, e.sc);
      check("wbError", 0, {15'd0, weA}, {15'd0, e.we});
    end
    if (qB.size() > 0) begin
      e = qB.pop_front();
      vectors++;
      check("issueAccept", 1, {15'd0, iaB}, {15'd0, e.ia});
      check("stall", 1, {15'd0, stB}, {15'd0, e.st});
      check("pendingMask", 1, {8'd0, pmB}, {8'd0, e.pm});
      check("pendingCount", 1, {12'd0, pcB}, {12'd0, e.pc});
      check("stallCount", 1, scB, e.sc);
      check("wbError", 1, {15'd0, weB}, {15'd0, e.we});
    end
  end

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    reset = 1'b0; issueValid = 1'b0; flush = 1'b0;
    rs = 3'd0; rt = 3'd0; rd = 3'd0; useRs = 1'b0; useRt = 1'b0; writesRd = 1'b0;
    wbValid = 1'b0; wbReg = 3'd0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0);
    repeat (4) cyc(1, 1, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 3, 0, 0, 1, 0, 0, 1, 3);
    cyc(1, 1, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 5, 0, 0, 1, 1, 5);
    cyc(1, 1, 0, 0, 0, 2, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 2, 0, 5, 1, 0, 1, 1, 2);
    cyc(1, 1, 0, 0, 0, 5, 0, 0, 1, 1, 5);
    cyc(1, 1, 0, 0, 0, 5, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 4, 0, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 4, 0, 0, 1, 0, 0, 0);
    repeat (20) cyc(1, 1, 0, 0, 4, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 4, 4, 4, 1, 1, 1, 0, 0);
    cyc(0, 1, 0, 4, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    cyc(1, 1, 0, 0, 0, 6, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 6, 6, 6, 1, 1, 1, 1, 6);
    cyc(1, 1, 0, 0, 0, 7, 0, 0, 1, 1, 6);
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    driverDone = 1;
  end

  initial begin
    int waitCycles;
    wait (driverDone);
    waitCycles = 0;
    while ((qA.size() > 0 || qB.size() > 0) && waitCycles < 10) begin
      @(posedge clock);
      waitCycles++;
    end
    if (qA.size() > 0 || qB.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", qA.size() + qB.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-hazard scoreboard for the ID stage of the 16-bit processor. Tracks which of the 8 architectural registers have a write in flight between issue and writeback, and decides each cycle whether the instruction in ID may issue or must stall. Sits between the instruction decoder and the register bank. Its writeback inputs are driven by the same WB-stage signals that drive the bank's RegWrite and rd.

## Interface
- WB_BYPASS, 1: 1 = a source being written back this cycle is not a hazard (bank write-through); 0 = it still stalls
- R0_ZERO, 1: 1 = register 0 is hardwired zero, never pending, never a hazard
- STALL_CNT_W, 16: width of the stall statistics counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- issueValid  in  1  decoder presents an instruction in ID
- flush  in  1  squash the instruction in ID this cycle
- rs  in  3  source register 1
- rt  in  3  source register 2
- rd  in  3  destination register
- useRs  in  1  instruction reads rs
- useRt  in  1  instruction reads rt
- writesRd  in  1  instruction writes rd
- wbValid  in  1  writeback of wbReg occurs this cycle
- wbReg  in  3  register being written back
- issueAccept  out  1  instruction leaves ID this cycle
- stall  out  1  issueValid & ~flush & hazard
- pendingMask  out  8  bit i = register i has a write in flight
- pendingCount  out  4  popcount of pendingMask
- stallCount  out  STALL_CNT_W  cycles with stall=1, saturating
- wbError  out  1  sticky: writeback to a non-pending register

## Operation
- State: pending[7:0], stallCount, wbError, pendingCount (registered, kept consistent with pending).
- The hazard is the OR of three terms:
  - srcHaz(rs) when useRs
  - srcHaz(rt) when useRt
  - pending[rd] when writesRd (WAW)
- srcHaz(r) = pending[r] & ~(WB_BYPASS & wbValid & wbReg==r).
- The WAW term is never bypassed.
- With R0_ZERO=1, any term on register 0 is 0.
- issueAccept = issueValid & ~flush & ~hazard. stall = issueValid & ~flush & hazard.
- flush overrides everything for the ID instruction: no accept, no stall, no state set.
- Per-register next state, in priority order:
  1. set if issueAccept & writesRd & rd==i (and not i==0 with R0_ZERO)
  2. else clear if wbValid & wbReg==i
  3. else hold
- Same-register set and clear in one cycle: set wins. The older write retires and the new write becomes pending.
- wbValid to a register with pending=0 (including r0 with R0_ZERO): no state change, wbError <= 1. This is sticky until reset.
- stallCount increments when stall=1 and saturates at all-ones. It does not wrap.
- pendingCount = number of ones in the next-state pending vector, registered. Range 0..8 (0..7 with R0_ZERO).

## Timing
- issueAccept and stall are combinational (same cycle) from inputs and current state.
- All state updates on the rising clock edge.
- A register set at edge N shows in pendingMask after edge N. A dependent instruction presented in the cycle after issue stalls.
- A writeback in cycle N clears pending at edge N.
  - WB_BYPASS=1: a dependent instruction may issue in cycle N itself.
  - WB_BYPASS=0: it issues in cycle N+1 at the earliest.
- Reset values:
  - pending = 0, pendingMask = 0, pendingCount = 0, stallCount = 0, wbError = 0.
  - issueAccept and stall follow their equations: with pending = 0, issueAccept = issueValid & ~flush and stall = 0.
- Reset mid-operation discards all in-flight tracking. Later writebacks of those registers set wbError.

## Test plan
- Reset with issueValid=0 -> all outputs 0. Issue writesRd rd=3 -> issueAccept=1, next cycle pendingMask=8'h08, pendingCount=1.
- With r3 pending, issue useRs rs=3 for 4 cycles -> stall=1 each cycle, issueAccept=0, stallCount=4. Assert wbValid wbReg=3 (WB_BYPASS=1) -> issueAccept=1 that cycle, pendingMask=0 after the edge.
- Same as above with WB_BYPASS=0 -> stall still 1 in the writeback cycle, issueAccept=1 the next cycle.
- Same-cycle writeback of r5 and accepted issue of writesRd rd=5 (r5 not pending before) -> pendingMask bit 5 = 1 after the edge, wbError=1. With r5 pending before and no WAW stall possible, the test instead checks that set beats clear via an r2→r5 sequence.
- Issue writesRd rd=0 with R0_ZERO=1 -> issueAccept=1, pendingMask stays 0. Then useRs rs=0 -> no stall.
- flush=1 with issueValid=1 on a hazarding instruction -> stall=0, issueAccept=0, stallCount unchanged. Force stallCount to saturation with STALL_CNT_W=4 over 20 stall cycles -> holds 4'hF.
